// File: rtl/output_wr_arbiter_pkg.sv
// Shared types and constants for the output-cache write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package output_wr_arbiter_pkg;

  // One burst in flight: grant, address phase, data phase, response wait.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int NREQ_DEFAULT   = 4;
  localparam int MAXLEN_DEFAULT = 31;

  // Every beat is a full 64-bit word on an incrementing burst.
  localparam logic [2:0] AWSIZE  = 3'd3;
  localparam logic [1:0] AWBURST = 2'b01;

  // Burst length (minus one) limited to what the downstream side accepts.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int maxlen);
    return (int'(len) > maxlen) ? 8'(maxlen) : len;
  endfunction

endpackage

// File: rtl/output_wr_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever any request is high.
module rr_pick
  import output_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW:0] pos;

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(NREQ)) pos = pos - (IW + 1)'(NREQ);
      if (req_i[pos[IW-1:0]]) begin
        vld_o = 1'b1;
        idx_o = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/output_wr_arbiter.sv
// Arbitrates NREQ output-cache write requesters onto one AXI write master, one burst at a time.
// Latency: AW valid 1 cycle after request seen in Idle; data muxed combinationally; Resp->Idle in 1 cycle.
// Backpressure: m_awready stalls Addr, m_wready stalls beats (wack follows it), m_bvalid gates next grant.
module output_wr_arbiter
  import output_wr_arbiter_pkg::*;
#(
  parameter int NREQ   = NREQ_DEFAULT,
  parameter int MAXLEN = MAXLEN_DEFAULT,
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic [NREQ-1:0]       wreq,
  input  logic [NREQ-1:0][31:0] wadr,
  input  logic [NREQ-1:0][7:0]  wlen,
  input  logic [NREQ-1:0][63:0] wdata,
  input  logic [NREQ-1:0][7:0]  wstb,
  output logic [NREQ-1:0]       wack,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [63:0]           m_wdata,
  output logic [7:0]            m_wstrb,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  busy,
  output logic [IW-1:0]         gnt
);

  state_e        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   awaddr_q, awaddr_d;
  logic [7:0]    awlen_q, awlen_d;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          last_beat;
  logic [IW-1:0] gnt_next;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req_i (wreq),
    .ptr_i (rr_ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign last_beat = (cnt_q == awlen_q);
  assign gnt_next  = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);

  // Data path follows the latched grant; only the Data state qualifies it.
  assign m_wdata  = wdata[gnt_q];
  assign m_wstrb  = wstb[gnt_q];
  assign m_awaddr = awaddr_q;
  assign m_awlen  = awlen_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != ST_IDLE);

  // Next-state and handshake outputs; wreq only matters in Idle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    wack      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick_idx;
          awaddr_d = wadr[pick_idx];
          awlen_d  = clamp_len(wlen[pick_idx], MAXLEN);
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_wvalid    = 1'b1;
        m_wlast     = last_beat;
        wack[gnt_q] = m_wready;
        if (m_wready) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          rr_ptr_d = gnt_next;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any burst in flight without completion.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
    end
  end

endmodule

// File: tb/tb_output_wr_arbiter.sv
// Self-checking bench for output_wr_arbiter: directed scenarios then randomized bursts.
// Latency: expects AW one cycle after Idle sampling, combinational data/wack.
// Backpressure: bench plays the AXI slave with programmable awready/wready/bvalid delays.
module tb_output_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int MAXLEN = 31;

  logic                  clk = 1'b0;
  logic                  xrst;
  logic [NREQ-1:0]       wreq;
  logic [NREQ-1:0][31:0] wadr;
  logic [NREQ-1:0][7:0]  wlen;
  logic [NREQ-1:0][63:0] wdata;
  logic [NREQ-1:0][7:0]  wstb;
  logic [NREQ-1:0]       wack;
  logic                  m_awvalid, m_awready;
  logic [31:0]           m_awaddr;
  logic [7:0]            m_awlen;
  logic                  m_wvalid, m_wready;
  logic [63:0]           m_wdata;
  logic [7:0]            m_wstrb;
  logic                  m_wlast;
  logic                  m_bvalid, m_bready;
  logic                  busy;
  logic [1:0]            gnt;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  bit fix_stb_en = 1'b0;
  logic [7:0] fix_stb = 8'h00;

  output_wr_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .xrst(xrst),
    .wreq(wreq), .wadr(wadr), .wlen(wlen), .wdata(wdata), .wstb(wstb), .wack(wack),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_winner(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic scramble(input int g);
    for (int i = 0; i < NREQ; i++) begin
      wdata[i] = {$urandom, $urandom};
      wstb[i]  = (fix_stb_en && i == g) ? fix_stb : 8'($urandom);
    end
  endtask

  // One full burst from Idle; wr_pat: 0 ready always, 1 toggling, 2 random.
  task automatic run_burst(input string nm, input int wr_pat, input int awdly, input int bdly);
    int g, len, beat, c;
    logic [31:0] eaddr;
    logic [NREQ-1:0] ewack;
    chk({nm, ":idle_busy"}, busy, 0);
    g = rr_winner(wreq, m_ptr);
    if (g < 0) begin
      chk({nm, ":no_request"}, 1, 0);
      return;
    end
    len   = (int'(wlen[g]) > MAXLEN) ? MAXLEN : int'(wlen[g]);
    eaddr = wadr[g];
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    @(posedge clk); #1;
    chk({nm, ":gnt"}, gnt, g);
    chk({nm, ":awaddr"}, m_awaddr, eaddr);
    chk({nm, ":awlen"}, m_awlen, len);
    chk({nm, ":busy"}, busy, 1);
    for (c = 0; c <= awdly; c++) begin
      m_awready = (c == awdly);
      #1;
      chk({nm, ":awvalid"}, m_awvalid, 1);
      chk({nm, ":wvalid_in_aw"}, m_wvalid, 0);
      @(posedge clk); #1;
    end
    m_awready = 1'b0;
    beat = 0;
    for (c = 0; c < 400 && beat <= len; c++) begin
      scramble(g);
      case (wr_pat)
        0:       m_wready = 1'b1;
        1:       m_wready = (c % 2 == 0);
        default: m_wready = 1'($urandom_range(0, 1));
      endcase
      #1;
      ewack = m_wready ? (NREQ'(1) << g) : '0;
      chk({nm, ":wvalid"}, m_wvalid, 1);
      chk({nm, ":awvalid_in_w"}, m_awvalid, 0);
      chk({nm, ":wdata"}, m_wdata, wdata[g]);
      chk({nm, ":wstrb"}, m_wstrb, wstb[g]);
      chk({nm, ":wlast"}, m_wlast, (beat == len));
      chk({nm, ":wack"}, wack, ewack);
      if (m_wready) begin
        beat++;
        wreq[g] = 1'b0;
      end
      @(posedge clk); #1;
    end
    m_wready = 1'b0;
    chk({nm, ":beats"}, beat, len + 1);
    for (c = 0; c <= bdly; c++) begin
      m_bvalid = (c == bdly);
      #1;
      chk({nm, ":bready"}, m_bready, 1);
      chk({nm, ":aw_in_resp"}, m_awvalid, 0);
      chk({nm, ":w_in_resp"}, m_wvalid, 0);
      @(posedge clk); #1;
    end
    m_bvalid = 1'b0;
    m_ptr = (g + 1) % NREQ;
    chk({nm, ":back_idle"}, busy, 0);
  endtask

  initial begin
    xrst = 1'b0; wreq = '0; wadr = '0; wlen = '0; wdata = '0; wstb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    #12;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wack", wack, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_awlen", m_awlen, 0);
    xrst = 1'b1;
    @(posedge clk); #1;

    // All four at once from pointer 0: grants 0,1,2,3 then 0 again.
    for (int i = 0; i < NREQ; i++) begin
      wadr[i] = 32'h2000 + 32'(i) * 32'h100;
      wlen[i] = 8'(i + 1);
    end
    wreq = 4'b1111;
    run_burst("all0", 0, 0, 0); chk("order_a", gnt, 0);
    run_burst("all1", 0, 1, 0); chk("order_b", gnt, 1);
    run_burst("all2", 0, 0, 1); chk("order_c", gnt, 2);
    run_burst("all3", 0, 0, 0); chk("order_d", gnt, 3);
    wreq[0] = 1'b1;
    run_burst("all0b", 0, 0, 0); chk("order_e", gnt, 0);

    // Single requester, 4 beats at 0x1000.
    wadr[0] = 32'h1000; wlen[0] = 8'd3; wreq = 4'b0001;
    run_burst("single", 0, 0, 0);

    // Toggling wready, 8 beats.
    wadr[1] = 32'h3000; wlen[1] = 8'd7; wreq = 4'b0010;
    run_burst("toggle", 1, 0, 0);

    // Zero-length burst with strobe 0x07.
    wadr[2] = 32'h4000; wlen[2] = 8'd0; wreq = 4'b0100;
    fix_stb_en = 1'b1; fix_stb = 8'h07;
    run_burst("len0", 0, 0, 0);
    fix_stb_en = 1'b0;

    // Oversized length clamps to MAXLEN.
    wadr[3] = 32'h5000; wlen[3] = 8'd200; wreq = 4'b1000;
    run_burst("clamp", 0, 0, 0);

    // Long response wait with req2 pending; req2's AW only after bvalid.
    wadr[0] = 32'h6000; wlen[0] = 8'd1; wadr[2] = 32'h7000; wlen[2] = 8'd2;
    wreq = 4'b0101;
    run_burst("bdly_r0", 0, 0, 10);
    run_burst("bdly_r2", 0, 0, 0);

    // Reset during beat 2 of 4 abandons the burst.
    wadr[0] = 32'h8000; wlen[0] = 8'd3; wreq = 4'b0001;
    m_awready = 1'b1; m_wready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_wvalid", m_wvalid, 1);
    xrst = 1'b0;
    #1;
    chk("mid_rst_awvalid", m_awvalid, 0);
    chk("mid_rst_wvalid", m_wvalid, 0);
    chk("mid_rst_wlast", m_wlast, 0);
    chk("mid_rst_bready", m_bready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wack", wack, 0);
    chk("mid_rst_gnt", gnt, 0);
    wreq = '0; m_awready = 1'b0; m_wready = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_hold_busy", busy, 0);
    xrst = 1'b1;
    m_ptr = 0;
    wadr[1] = 32'h9000; wlen[1] = 8'd2; wreq = 4'b0010;
    run_burst("after_rst", 0, 0, 0);
    chk("after_rst_gnt", gnt, 1);

    // Randomized bursts.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        wadr[i] = {$urandom} & 32'hFFFF_FFF8;
        wlen[i] = 8'($urandom_range(0, 40));
      end
      wreq = 4'($urandom_range(1, 15));
      run_burst("rand", $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_wr_arbiter.md
OUTPUT_WR_ARBITER -- requirements
Module: output_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of output_cache write requesters.
REQ-002 SHALL have parameter MAXLEN, default 31: largest accepted burst length minus 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port xrst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port wreq, input, NREQ bits: per-requester burst request; held until that requester's first wack.
REQ-006 SHALL have port wadr, input, NREQ x 32 bits: per-requester burst byte address.
REQ-007 SHALL have port wlen, input, NREQ x 8 bits: per-requester burst length minus 1.
REQ-008 SHALL have port wdata, input, NREQ x 64 bits: per-requester current beat data.
REQ-009 SHALL have port wstb, input, NREQ x 8 bits: per-requester current beat byte strobe.
REQ-010 SHALL have port wack, output, NREQ bits: per-requester beat accept.
REQ-011 SHALL have AXI write-address ports: m_awvalid output 1, m_awready input 1, m_awaddr output 32, m_awlen output 8.
REQ-012 SHALL have AXI write-data ports: m_wvalid output 1, m_wready input 1, m_wdata output 64, m_wstrb output 8, m_wlast output 1.
REQ-013 SHALL have AXI write-response ports: m_bvalid input 1, m_bready output 1.
REQ-014 SHALL have port busy, output, 1 bit: high while any state other than Idle is active.
REQ-015 SHALL have port gnt, output, clog2(NREQ) bits: index of the current or last granted requester.

Function
REQ-016 SHALL implement states Idle, Addr, Data, Resp; only one burst is outstanding at a time.
REQ-017 In Idle with any wreq high: SHALL pick a winner round-robin, starting at index rr_ptr; SHALL latch gnt, awaddr = wadr[gnt] and awlen = wlen[gnt]; next state Addr.
REQ-018 In Addr: m_awvalid = 1, with address and length stable; on m_awready, next state Data.
REQ-019 In Data: m_wvalid = 1; m_wdata and m_wstrb SHALL be combinational muxes of wdata[gnt] and wstb[gnt].
REQ-020 In Data: wack[gnt] = m_wvalid and m_wready, combinationally; all other wack bits = 0.
REQ-021 In Data: an 8-bit beat counter SHALL increment per handshake; m_wlast = (count == awlen).
REQ-022 A handshake with m_wlast high: SHALL clear the counter; next state Resp.
REQ-023 In Resp: m_bready = 1; on m_bvalid, rr_ptr = (gnt + 1) mod NREQ; next state Idle.
REQ-024 wreq SHALL be ignored outside Idle; a requester dropping wreq mid-burst SHALL NOT abort the burst.
REQ-025 An 8-bit wlen greater than MAXLEN SHALL be clamped to MAXLEN when latched.
REQ-026 wlen = 0 SHALL produce a single beat with m_wlast high.
REQ-027 Latency: m_awvalid SHALL rise 1 cycle after wreq is sampled in Idle; Resp to Idle SHALL take 1 cycle, with no idle bubble before the next grant evaluation.
REQ-028 m_awvalid and m_wvalid SHALL NOT be high in the same cycle.

Reset
REQ-029 On xrst low, asynchronously: state = Idle, rr_ptr = 0, gnt = 0, counter = 0, awaddr = 0, awlen = 0.
REQ-030 Outputs while xrst is low: m_awvalid, m_wvalid, m_wlast, m_bready, busy and all wack = 0.
REQ-031 Reset mid-burst SHALL abandon the burst; no completion is signalled.

Structure
REQ-032 A shared package SHALL hold the state enum, default NREQ, MAXLEN, and AXI constants AWSIZE = 3 (8 bytes) and AWBURST = INCR.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick: inputs req vector and rr_ptr; outputs valid and index.

Verification
REQ-034 Single requester: req0, wadr 0x1000, wlen 3, m_awready and m_wready tied 1 -> one AW at 0x1000 with len 3; 4 beats; wack[0] pulses 4 times; m_wlast on beat 4.
REQ-035 All four wreq high at once, rr_ptr 0 -> grant order 0, 1, 2, 3, then back to 0 if req0 is reasserted.
REQ-036 m_wready toggling 1, 0, 1, 0 -> wack high only in ready cycles; data from the granted port only; 8 beats complete for wlen 7.
REQ-037 wlen 0 with m_wstb 0x07 -> single beat, m_wlast = 1, m_wstrb = 0x07.
REQ-038 xrst asserted during beat 2 of 4 -> all outputs 0 immediately; after release, a fresh req1 is granted with gnt = 1.
REQ-039 m_bvalid delayed 10 cycles with req2 pending -> req2's AW is issued only after the bvalid handshake.
